nibble_frame_receiver: RTL

Serial receiver for the 4-bit frame link. It decodes a single-bit line `Z`, carrying start, four data bits, parity and stop, back into the parallel bits `A`, `B`, `C`, `D`, and qualifies each frame with a one-cycle `valid` pulse and error flags. It sits at the far end of the `Z` output of the existing combine/register pipeline and feeds the next stage's `A..D` inputs. `Z` is synchronous to `clk`, so the block has no synchronizer.

---
 rtl/nibble_frame_receiver_pkg.sv | 29 ++
 rtl/bit_timer.sv | 34 +++
 rtl/nibble_frame_receiver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nibble_frame_receiver_pkg.sv
// Shared definitions for the nibble frame link: state encodings, nibble width
// and the parity rule, also intended for the future transmitter.
package nibble_frame_receiver_pkg;

  localparam int NIBBLE_BITS = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_BREAK  = ST_BREAK
  } state_e;

  // True when the received parity bit disagrees with the selected parity sense.
  function automatic logic parity_bad(input logic [NIBBLE_BITS-1:0] data,
                                      input logic par, input logic odd);
    return (^data ^ par) != odd;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter; emits a one-cycle tick at the half-bit or full-bit
// terminal count and wraps to zero on every tick.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int H  = BIT_CYCLES / 2;
  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] TC_FULL = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TC_HALF = TW'(H - 1);

  logic [TW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == (half ? TC_HALF : TC_FULL));
  assign tick   = w_term && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_frame_receiver.sv
// Serial receiver for the 4-bit frame link: start, A..D, parity, stop on Z,
// decoded to registered A..D with a valid pulse and parity/framing flags.
module nibble_frame_receiver
  import nibble_frame_receiver_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic Z,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic valid,
  output logic parity_err,
  output logic frame_err,
  output logic busy
);

  localparam logic ODD = (PARITY_ODD != 0);

  state_e                 r_state;
  logic [1:0]             r_idx;
  logic [NIBBLE_BITS-1:0] r_shift;
  logic [NIBBLE_BITS-1:0] r_data;
  logic                   r_par;
  logic                   r_stop;
  logic                   r_fin;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_busy;
  logic                   w_tick;
  logic                   w_clear;
  logic                   w_half;

  assign w_clear = (r_state == S_IDLE) || (r_state == S_BREAK);
  assign w_half  = (r_state == S_START);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .half (w_half),
    .tick (w_tick)
  );

  assign A          = r_data[0];
  assign B          = r_data[1];
  assign C          = r_data[2];
  assign D          = r_data[3];
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      r_fin   <= 1'b0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx  <= '0;
          r_fin  <= 1'b0;
          r_busy <= 1'b0;
          if (!Z) r_state <= S_START;
        end
        S_START: begin
          r_busy <= 1'b1;
          if (w_tick) begin
            if (Z) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift[r_idx] <= Z;
            r_idx          <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par   <= Z;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // The stop bit is latched on the tick; outputs commit one cycle later.
          if (r_fin) begin
            r_fin   <= 1'b0;
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_perr  <= parity_bad(r_shift, r_par, ODD);
            r_ferr  <= !r_stop;
            if (r_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_BREAK;
            end
          end else if (w_tick) begin
            r_stop <= Z;
            r_fin  <= 1'b1;
          end
        end
        S_BREAK: begin
          if (Z) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
